// File: rtl/core0_pkg.sv
// Shared widths and types for core0's instruction-fetch path.
package core0_pkg;

  localparam int PMEM_WIDTH = 10;
  localparam int INSN_W     = 16;
  localparam int RESET_PC   = 0;

  typedef logic [PMEM_WIDTH-1:0] pc_t;
  typedef logic [INSN_W-1:0]     insn_t;

  typedef struct packed {
    insn_t insn;
    pc_t   pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch queue: synchronous FIFO with a flush that dominates push and pop.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int DW    = 26
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [DW-1:0]            din,
  input  logic                     pop,
  output logic [DW-1:0]            head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;

  // The extra pointer bit distinguishes full from empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: the storage array is deliberately not reset; the pointers alone decide
  // which entries are meaningful, and the top masks the head while empty.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr[AW-1:0]] <= din;
  end

  assign head  = mem[rd_ptr[AW-1:0]];
  assign count = wr_ptr - rd_ptr;

endmodule

// File: rtl/pmem_fetch.sv
// Instruction-fetch initiator: sequential PC, one-deep request pipeline into the
// flash, prefetch queue toward decode, and single-cycle redirect with flush.
module pmem_fetch
  import core0_pkg::INSN_W;
#(
  parameter int PMEM_WIDTH = core0_pkg::PMEM_WIDTH,
  parameter int QDEPTH     = 4,
  parameter int RESET_PC   = core0_pkg::RESET_PC
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  pmem_ce,
  output logic [PMEM_WIDTH-1:0] pmem_a,
  input  logic [INSN_W-1:0]     pmem_d,
  input  logic                  redirect,
  input  logic [PMEM_WIDTH-1:0] redirect_pc,
  output logic                  insn_valid,
  output logic [INSN_W-1:0]     insn,
  output logic [PMEM_WIDTH-1:0] insn_pc,
  input  logic                  insn_ready
);

  localparam int CW = $clog2(QDEPTH) + 1;
  localparam int EW = INSN_W + PMEM_WIDTH;

  logic [PMEM_WIDTH-1:0] fetch_pc;
  logic [PMEM_WIDTH-1:0] req_pc;
  logic                  inflight;

  logic [CW-1:0]         count;
  logic [EW-1:0]         head;
  logic                  pop;
  logic                  push;
  logic                  issue;
  logic [PMEM_WIDTH-1:0] issue_pc;
  logic [CW:0]           credit_use;

  // NOTE: every signal driven here gets a value on every path, so no latches form.
  always_comb begin
    pop        = insn_valid & insn_ready;
    credit_use = (CW+1)'(count) + (CW+1)'(inflight) - (CW+1)'(pop);
    // rst_n gates the strobe so the flash sees no request while reset is held.
    issue      = rst_n & (redirect | (credit_use < (CW+1)'(QDEPTH)));
    issue_pc   = redirect ? redirect_pc : fetch_pc;
    // A redirect kills the response of whatever request is currently in flight.
    push       = inflight & ~redirect;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc <= PMEM_WIDTH'(RESET_PC);
      req_pc   <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        req_pc   <= issue_pc;
        fetch_pc <= issue_pc + 1'b1;
      end
    end
  end

  fetch_fifo #(
    .DEPTH (QDEPTH),
    .DW    (EW)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (redirect),
    .push  (push),
    .din   ({pmem_d, req_pc}),
    .pop   (pop),
    .head  (head),
    .count (count)
  );

  assign pmem_ce    = issue;
  assign pmem_a     = rst_n ? issue_pc : '0;
  assign insn_valid = (count != '0);
  assign insn       = insn_valid ? head[EW-1:PMEM_WIDTH] : '0;
  assign insn_pc    = insn_valid ? head[PMEM_WIDTH-1:0]  : '0;

endmodule

// File: tb/tb_pmem_fetch.sv
// Directed bench for pmem_fetch with a one-cycle-latency flash model.
module tb_pmem_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pmem_ce;
  logic [9:0]  pmem_a;
  logic [15:0] pmem_d;
  logic        redirect;
  logic [9:0]  redirect_pc;
  logic        insn_valid;
  logic [15:0] insn;
  logic [9:0]  insn_pc;
  logic        insn_ready;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pmem_fetch dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pmem_ce     (pmem_ce),
    .pmem_a      (pmem_a),
    .pmem_d      (pmem_d),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .insn_valid  (insn_valid),
    .insn        (insn),
    .insn_pc     (insn_pc),
    .insn_ready  (insn_ready)
  );

  function automatic logic [15:0] flash(input logic [9:0] a);
    return {6'b101010, a};
  endfunction

  // Flash: address sampled at edge k, data valid through cycle k+1.
  always @(posedge clk) pmem_d <= pmem_ce ? flash(pmem_a) : 16'hDEAD;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle, apply inputs, let combinational outputs settle.
  task automatic cyc(input logic rd, input logic [9:0] rpc, input logic rdy);
    @(posedge clk);
    #1;
    redirect    = rd;
    redirect_pc = rpc;
    insn_ready  = rdy;
    #1;
  endtask

  task automatic release_rst(input logic rdy);
    @(posedge clk);
    #1;
    rst_n      = 1'b1;
    redirect   = 1'b0;
    insn_ready = rdy;
    #1;
  endtask

  task automatic enter_rst();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".ce"},    32'(pmem_ce),    32'h0);
    chk({tag, ".a"},     32'(pmem_a),     32'h0);
    chk({tag, ".valid"}, 32'(insn_valid), 32'h0);
    chk({tag, ".insn"},  32'(insn),       32'h0);
    chk({tag, ".pc"},    32'(insn_pc),    32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    insn_ready  = 1'b1;
    #12;
    chk_reset_vals("por");

    // Free-running fetch from RESET_PC with decode always ready.
    release_rst(1'b1);
    chk("seq.c0.ce", 32'(pmem_ce), 32'h1);
    chk("seq.c0.a", 32'(pmem_a), 32'h0);
    chk("seq.c0.valid", 32'(insn_valid), 32'h0);
    cyc(1'b0, '0, 1'b1);
    chk("seq.c1.a", 32'(pmem_a), 32'h1);
    chk("seq.c1.valid", 32'(insn_valid), 32'h0);
    for (int n = 2; n < 7; n++) begin
      cyc(1'b0, '0, 1'b1);
      chk("seq.a", 32'(pmem_a), 32'(n));
      chk("seq.valid", 32'(insn_valid), 32'h1);
      chk("seq.pc", 32'(insn_pc), 32'(n - 2));
      chk("seq.insn", 32'(insn), 32'(flash(10'(n - 2))));
    end

    // Stall from reset: four requests fill the queue, then fetch stops.
    enter_rst();
    chk_reset_vals("mid_rst1");
    release_rst(1'b0);
    chk("stall.c0.a", 32'(pmem_a), 32'h0);
    for (int n = 1; n < 4; n++) begin
      cyc(1'b0, '0, 1'b0);
      chk("stall.ce", 32'(pmem_ce), 32'h1);
      chk("stall.a", 32'(pmem_a), 32'(n));
    end
    for (int n = 4; n < 6; n++) begin
      cyc(1'b0, '0, 1'b0);
      chk("stall.idle.ce", 32'(pmem_ce), 32'h0);
    end
    chk("stall.head.valid", 32'(insn_valid), 32'h1);
    chk("stall.head.pc", 32'(insn_pc), 32'h0);
    cyc(1'b0, '0, 1'b1);
    chk("unstall.ce", 32'(pmem_ce), 32'h1);
    chk("unstall.a", 32'(pmem_a), 32'h4);
    chk("unstall.pc0", 32'(insn_pc), 32'h0);
    for (int n = 1; n < 5; n++) begin
      cyc(1'b0, '0, 1'b1);
      chk("unstall.pc", 32'(insn_pc), 32'(n));
      chk("unstall.insn", 32'(insn), 32'(flash(10'(n))));
    end

    // Redirect with 3 queued words and one request in flight.
    enter_rst();
    release_rst(1'b0);
    for (int n = 1; n < 4; n++) cyc(1'b0, '0, 1'b0);
    cyc(1'b1, 10'h155, 1'b0);
    chk("redir.ce", 32'(pmem_ce), 32'h1);
    chk("redir.a", 32'(pmem_a), 32'h155);
    cyc(1'b0, '0, 1'b1);
    chk("redir.r1.valid", 32'(insn_valid), 32'h0);
    chk("redir.r1.a", 32'(pmem_a), 32'h156);
    cyc(1'b0, '0, 1'b1);
    chk("redir.r2.valid", 32'(insn_valid), 32'h1);
    chk("redir.r2.pc", 32'(insn_pc), 32'h155);
    chk("redir.r2.insn", 32'(insn), 32'(flash(10'h155)));
    cyc(1'b0, '0, 1'b1);
    chk("redir.r3.pc", 32'(insn_pc), 32'h156);

    // Address wrap at the top of program memory.
    cyc(1'b1, 10'h3FE, 1'b1);
    chk("wrap.a0", 32'(pmem_a), 32'h3FE);
    cyc(1'b0, '0, 1'b1);
    chk("wrap.a1", 32'(pmem_a), 32'h3FF);
    chk("wrap.valid0", 32'(insn_valid), 32'h0);
    cyc(1'b0, '0, 1'b1);
    chk("wrap.a2", 32'(pmem_a), 32'h000);
    chk("wrap.pc0", 32'(insn_pc), 32'h3FE);
    cyc(1'b0, '0, 1'b1);
    chk("wrap.a3", 32'(pmem_a), 32'h001);
    chk("wrap.pc1", 32'(insn_pc), 32'h3FF);
    cyc(1'b0, '0, 1'b1);
    chk("wrap.pc2", 32'(insn_pc), 32'h000);
    chk("wrap.insn2", 32'(insn), 32'(flash(10'h000)));
    cyc(1'b0, '0, 1'b1);
    chk("wrap.pc3", 32'(insn_pc), 32'h001);

    // Back-to-back redirects: only the second target is delivered.
    cyc(1'b1, 10'h010, 1'b1);
    chk("b2b.a0", 32'(pmem_a), 32'h010);
    cyc(1'b1, 10'h020, 1'b1);
    chk("b2b.a1", 32'(pmem_a), 32'h020);
    chk("b2b.valid1", 32'(insn_valid), 32'h0);
    cyc(1'b0, '0, 1'b1);
    chk("b2b.valid2", 32'(insn_valid), 32'h0);
    chk("b2b.a2", 32'(pmem_a), 32'h021);
    cyc(1'b0, '0, 1'b1);
    chk("b2b.valid3", 32'(insn_valid), 32'h1);
    chk("b2b.pc3", 32'(insn_pc), 32'h020);
    cyc(1'b0, '0, 1'b1);
    chk("b2b.pc4", 32'(insn_pc), 32'h021);

    // One-cycle reset pulse mid-stream; the response in the reset cycle is dropped.
    enter_rst();
    chk_reset_vals("mid_rst2");
    release_rst(1'b1);
    chk("rst.c0.a", 32'(pmem_a), 32'h0);
    chk("rst.c0.valid", 32'(insn_valid), 32'h0);
    cyc(1'b0, '0, 1'b1);
    chk("rst.c1.valid", 32'(insn_valid), 32'h0);
    cyc(1'b0, '0, 1'b1);
    chk("rst.c2.pc", 32'(insn_pc), 32'h0);
    chk("rst.c2.insn", 32'(insn), 32'(flash(10'h0)));
    cyc(1'b0, '0, 1'b1);
    chk("rst.c3.pc", 32'(insn_pc), 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
